adder_share_arbiter: RTL

//  Shares one external ripple-carry adder (e.g. adder_48bit) among NREQ requesters.

---
 rtl/adder_share_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//
// Shares one external adder among NREQ requesters. A round-robin arbiter picks
// one request in IDLE, registers its operands onto the adder inputs, holds them
// for ADD_CYCLES cycles (multicycle path through the adder), then captures the
// sum/carry into a single response channel held until rsp_ready_i.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   req_valid_i  per-requester request valid            [NREQ]
//   req_ready_o  per-requester accept, one-hot or zero   [NREQ]
//   req_a_i      operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b_i      operand B, same packing
//   add_in1_o    registered operand A to shared adder
//   add_in2_o    registered operand B to shared adder
//   add_s_i      adder sum
//   add_cout_i   adder carry-out
//   rsp_valid_o  response valid
//   rsp_ready_i  response accept
//   rsp_id_o     index of the requester owning the response
//   rsp_sum_o    captured sum
//   rsp_cout_o   captured carry
//   busy_o       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
   parameter int NREQ       = 4,
   parameter int WIDTH      = 48,
   parameter int ADD_CYCLES = 2,
   parameter int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_valid_i,
   output logic [NREQ-1:0]       req_ready_o,
   input  logic [NREQ*WIDTH-1:0] req_a_i,
   input  logic [NREQ*WIDTH-1:0] req_b_i,
   output logic [WIDTH-1:0]      add_in1_o,
   output logic [WIDTH-1:0]      add_in2_o,
   input  logic [WIDTH-1:0]      add_s_i,
   input  logic                  add_cout_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [IDW-1:0]        rsp_id_o,
   output logic [WIDTH-1:0]      rsp_sum_o,
   output logic                  rsp_cout_o,
   output logic                  busy_o
);

   // Counter wide enough to hold ADD_CYCLES-1 (one bit minimum).
   localparam int CW = (ADD_CYCLES > 1) ? $clog2(ADD_CYCLES) + 1 : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state_q;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     id_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   add_in1_q;
   logic [WIDTH-1:0]   add_in2_q;
   logic               rsp_valid_q;
   logic [IDW-1:0]     rsp_id_q;
   logic [WIDTH-1:0]   rsp_sum_q;
   logic               rsp_cout_q;

   logic               gnt_found_s;
   logic [IDW-1:0]     gnt_idx_s;
   logic [NREQ-1:0]    gnt_oh_s;
   logic [IDW-1:0]     cand_s;
   logic [WIDTH-1:0]   gnt_a_s;
   logic [WIDTH-1:0]   gnt_b_s;

   // Round-robin search: first valid requester starting at ptr+1, wrapping at NREQ-1.
   always_comb begin
      gnt_found_s = 1'b0;
      gnt_idx_s   = '0;
      gnt_oh_s    = '0;
      cand_s      = (ptr_q == IDW'(NREQ-1)) ? '0 : ptr_q + 1'b1;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found_s && req_valid_i[cand_s]) begin
            gnt_found_s       = 1'b1;
            gnt_idx_s         = cand_s;
            gnt_oh_s[cand_s]  = 1'b1;
         end else begin
            gnt_found_s = gnt_found_s;
         end
         cand_s = (cand_s == IDW'(NREQ-1)) ? '0 : cand_s + 1'b1;
      end
   end

   assign gnt_a_s     = req_a_i[gnt_idx_s*WIDTH +: WIDTH];
   assign gnt_b_s     = req_b_i[gnt_idx_s*WIDTH +: WIDTH];

   // Ready is only offered in IDLE, so an accept always coincides with gnt_found_s.
   assign req_ready_o = (state_q == S_IDLE) ? gnt_oh_s : '0;

   // Control FSM plus all datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         ptr_q       <= IDW'(NREQ-1);
         id_q        <= '0;
         cnt_q       <= '0;
         add_in1_q   <= '0;
         add_in2_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt_found_s) begin
                  add_in1_q <= gnt_a_s;
                  add_in2_q <= gnt_b_s;
                  ptr_q     <= gnt_idx_s;
                  id_q      <= gnt_idx_s;
                  cnt_q     <= CW'(ADD_CYCLES-1);
                  state_q   <= S_EXEC;
               end
            end
            S_EXEC: begin
               // The adder has settled for ADD_CYCLES cycles once cnt reaches 0.
               if (cnt_q == '0) begin
                  rsp_sum_q   <= add_s_i;
                  rsp_cout_q  <= add_cout_i;
                  rsp_id_q    <= id_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign add_in1_o   = add_in1_q;
   assign add_in2_o   = add_in2_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_sum_o   = rsp_sum_q;
   assign rsp_cout_o  = rsp_cout_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule
